instr_encoder_loader: RTL and testbench

- Inverse of the datapath's field splitter: assembles MIPS R/I/J instruction words from discrete fields.
- Streams the encoded words, each paired with a sequential instruction-memory byte address, to the IM loader port.
- Used by the self-test and boot-load path to fill IM without a file preload.
- Input and output both use valid/ready handshakes, with one registered output stage.

---
 rtl/instr_encoder_loader.sv | 109 ++++++++++
 tb/tb_instr_encoder_loader.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_encoder_loader.sv
// Packs MIPS R/I/J field bundles into 32-bit instruction words and streams them,
// each with its sequential IM byte address, to the instruction-memory loader port.
module instr_encoder_loader #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_3000,
  parameter int          DEPTH     = 1024
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [1:0]               fmt,
  input  logic [5:0]               opcode,
  input  logic [4:0]               rs,
  input  logic [4:0]               rt,
  input  logic [4:0]               rd,
  input  logic [4:0]               shamt,
  input  logic [5:0]               funct,
  input  logic [15:0]              imm16,
  input  logic [25:0]              address,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [31:0]              out_instr,
  output logic [31:0]              out_addr,
  output logic [$clog2(DEPTH):0]   word_count,
  output logic                     wrapped,
  output logic                     err
);

  localparam int IW = $clog2(DEPTH);
  localparam int CW = IW + 1;

  localparam logic [1:0] FMT_R = 2'b00;
  localparam logic [1:0] FMT_I = 2'b01;
  localparam logic [1:0] FMT_J = 2'b10;

  // Output stage state; out_valid is the externally visible copy of it.
  localparam logic [0:0] ST_EMPTY = 1'b0;
  localparam logic [0:0] ST_FULL  = 1'b1;

  localparam logic [IW-1:0] IDX_LAST  = IW'(DEPTH - 1);
  localparam logic [CW-1:0] COUNT_MAX = CW'(DEPTH);

  logic [0:0]    state;
  logic [IW-1:0] idx;
  logic [IW-1:0] idx_after;
  logic          in_fire;
  logic          out_fire;
  logic          fmt_ok;
  logic [31:0]   enc_word;
  logic [31:0]   next_addr;

  // Handshakes: a transfer happens on a rising edge where valid && ready; once
  // out_valid rises, out_instr/out_addr stay stable until the word is taken.
  // in_ready depends only on the output stage, never on in_valid.
  assign out_valid = (state == ST_FULL);
  assign in_ready  = !out_valid || out_ready;
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_valid && out_ready;
  assign fmt_ok    = (fmt != 2'b11);

  // A word loaded in the same cycle the held one leaves takes the following slot.
  assign idx_after = out_fire ? idx + IW'(1) : idx;
  assign next_addr = BASE_ADDR + {{(30 - IW){1'b0}}, idx_after, 2'b00};

  always_comb begin
    enc_word = '0;
    case (fmt)
      FMT_R:   enc_word = {6'b0, rs, rt, rd, shamt, funct};
      FMT_I:   enc_word = {opcode, rs, rt, imm16};
      FMT_J:   enc_word = {opcode, address};
      default: enc_word = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_EMPTY;
      out_instr  <= '0;
      out_addr   <= BASE_ADDR;
      idx        <= '0;
      word_count <= '0;
      wrapped    <= 1'b0;
      err        <= 1'b0;
    end else if (flush) begin
      state      <= ST_EMPTY;
      out_addr   <= BASE_ADDR;
      idx        <= '0;
      word_count <= '0;
      wrapped    <= 1'b0;
      err        <= 1'b0;
    end else begin
      if (out_fire) begin
        idx <= idx + IW'(1);
        if (idx == IDX_LAST) wrapped <= 1'b1;
        if (word_count != COUNT_MAX) word_count <= word_count + CW'(1);
      end
      if (in_fire && !fmt_ok) err <= 1'b1;
      if (in_fire && fmt_ok) begin
        state     <= ST_FULL;
        out_instr <= enc_word;
        out_addr  <= next_addr;
      end else if (out_fire) begin
        state <= ST_EMPTY;
      end
    end
  end

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Bench for instr_encoder_loader (DEPTH=4): vector table through a scoreboard,
// plus hand-written backpressure, reserved-format, wrap, flush and reset sequences.
module tb_instr_encoder_loader;

  localparam logic [31:0] BASE  = 32'h0000_3000;
  localparam int          DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [1:0]  fmt = '0;
  logic [5:0]  opcode = '0;
  logic [4:0]  rs = '0, rt = '0, rd = '0, shamt = '0;
  logic [5:0]  funct = '0;
  logic [15:0] imm16 = '0;
  logic [25:0] address = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_instr;
  logic [31:0] out_addr;
  logic [2:0]  word_count;
  logic        wrapped;
  logic        err;

  typedef struct {
    logic [1:0]  fmt;
    logic [5:0]  opcode;
    logic [4:0]  rs, rt, rd, shamt;
    logic [5:0]  funct;
    logic [15:0] imm16;
    logic [25:0] address;
    logic [31:0] exp_instr;
  } vec_t;

  vec_t        vecs[8];
  vec_t        resv;
  logic [63:0] exp_q[$];
  logic [1:0]  model_idx = '0;
  int          n_checks = 0;
  int          n_pass = 0;
  int          stall_cnt = 0;

  instr_encoder_loader #(.BASE_ADDR(BASE), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset_n(reset_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .fmt(fmt), .opcode(opcode), .rs(rs), .rt(rt), .rd(rd), .shamt(shamt),
    .funct(funct), .imm16(imm16), .address(address),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_addr(out_addr),
    .word_count(word_count), .wrapped(wrapped), .err(err)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1);
  end

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, required %h", name, act, exp);
  endtask

  function automatic logic [31:0] model_enc(input vec_t v);
    case (v.fmt)
      2'b00:   return {6'b0, v.rs, v.rt, v.rd, v.shamt, v.funct};
      2'b01:   return {v.opcode, v.rs, v.rt, v.imm16};
      2'b10:   return {v.opcode, v.address};
      default: return 32'h0;
    endcase
  endfunction

  function automatic vec_t mk(input logic [1:0] f, input logic [5:0] op,
                              input logic [4:0] s, input logic [4:0] t,
                              input logic [4:0] d, input logic [4:0] sh,
                              input logic [5:0] fn, input logic [15:0] im,
                              input logic [25:0] ad, input logic [31:0] ex);
    vec_t v;
    v.fmt = f; v.opcode = op; v.rs = s; v.rt = t; v.rd = d; v.shamt = sh;
    v.funct = fn; v.imm16 = im; v.address = ad; v.exp_instr = ex;
    return v;
  endfunction

  // ---------------- driver tasks ----------------
  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send(input vec_t v);
    int waited;
    waited = 0;
    fmt = v.fmt; opcode = v.opcode; rs = v.rs; rt = v.rt; rd = v.rd;
    shamt = v.shamt; funct = v.funct; imm16 = v.imm16; address = v.address;
    in_valid = 1'b1;
    @(negedge clk);
    if (!in_ready) stall_cnt++;
    while (!in_ready && waited < 50) begin
      waited++;
      @(negedge clk);
    end
    if (!in_ready) begin
      n_checks++;
      $display("FAIL send_timeout: in_ready got 0, required 1 within 50 cycles");
    end else if (v.fmt != 2'b11) begin
      exp_q.push_back({v.exp_instr, BASE + {28'b0, model_idx, 2'b00}});
      model_idx++;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int waited;
    waited = 0;
    while (exp_q.size() != 0 && waited < 50) begin
      waited++;
      @(negedge clk);
    end
    if (exp_q.size() != 0) begin
      n_checks++;
      $display("FAIL drain_timeout: pending words got %0d, required 0", exp_q.size());
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_flush();
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    exp_q.delete();
    model_idx = '0;
  endtask

  // ---------------- scoreboard ----------------
  always @(negedge clk) begin
    logic [63:0] e;
    if (reset_n && !flush && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_word: got %h @ %h, required no word", out_instr, out_addr);
      end else begin
        e = exp_q.pop_front();
        check("out_instr", out_instr, e[63:32]);
        check("out_addr", out_addr, e[31:0]);
      end
    end
  end

  // ---------------- test sequence ----------------
  initial begin
    vecs[0] = mk(2'b00, 6'h3F, 5'd10, 5'd11, 5'd9, 5'd0, 6'h20, 16'hFFFF, 26'h3FFFFFF, 32'h014B4820);
    vecs[1] = mk(2'b01, 6'h0D, 5'd0, 5'd8, 5'h1F, 5'h1F, 6'h3F, 16'h1234, 26'h3FFFFFF, 32'h34081234);
    vecs[2] = mk(2'b10, 6'h02, 5'h1F, 5'h1F, 5'h1F, 5'h1F, 6'h3F, 16'hFFFF, 26'h0100000, 32'h08100000);
    vecs[3] = mk(2'b01, 6'h23, 5'd29, 5'd8, 5'h15, 5'h0A, 6'h11, 16'h0004, 26'h2AAAAAA, 32'h8FA80004);
    for (int i = 4; i < 8; i++) begin
      vecs[i] = mk(2'(($urandom_range(0, 2))), 6'($urandom), 5'($urandom), 5'($urandom),
                   5'($urandom), 5'($urandom), 6'($urandom), 16'($urandom),
                   26'($urandom), 32'h0);
      vecs[i].exp_instr = model_enc(vecs[i]);
    end
    resv = mk(2'b11, 6'($urandom), 5'($urandom), 5'($urandom), 5'($urandom),
              5'($urandom), 6'($urandom), 16'($urandom), 26'($urandom), 32'h0);

    // Reset state
    #2 reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_instr", out_instr, 32'h0);
    check("rst_out_addr", out_addr, BASE);
    check("rst_word_count", 32'(word_count), 32'd0);
    check("rst_wrapped", 32'(wrapped), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    // Table, back-to-back with the loader always ready
    out_ready = 1'b1;
    stall_cnt = 0;
    for (int i = 0; i < 8; i++) send(vecs[i]);
    drain();
    check("b2b_in_ready_stalls", 32'(stall_cnt), 32'd0);
    check("b2b_word_count_sat", 32'(word_count), 32'd4);
    check("b2b_wrapped", 32'(wrapped), 32'd1);

    // Flush clears counters; explicit wrap one word at a time
    do_flush();
    check("flush_word_count", 32'(word_count), 32'd0);
    check("flush_wrapped", 32'(wrapped), 32'd0);
    for (int i = 0; i < 5; i++) begin
      send(vecs[i]);
      drain();
      if (i == 2) check("wrap_not_yet", 32'(wrapped), 32'd0);
      if (i == 3) begin
        check("wrap_after_4th", 32'(wrapped), 32'd1);
        check("wrap_count_4", 32'(word_count), 32'd4);
      end
    end
    check("wrap_count_sat", 32'(word_count), 32'd4);

    // Backpressure: held word and address stay stable
    do_flush();
    out_ready = 1'b0;
    send(vecs[3]);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("bp_out_valid", 32'(out_valid), 32'd1);
      check("bp_out_instr", out_instr, 32'h8FA80004);
      check("bp_out_addr", out_addr, BASE);
      check("bp_in_ready", 32'(in_ready), 32'd0);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    drain();
    check("bp_word_count", 32'(word_count), 32'd1);
    check("bp_out_valid_after", 32'(out_valid), 32'd0);

    // Reserved format: consumed, err set, no word
    do_flush();
    send(resv);
    check("resv_err", 32'(err), 32'd1);
    check("resv_out_valid", 32'(out_valid), 32'd0);
    @(posedge clk);
    #1;
    check("resv_out_valid_later", 32'(out_valid), 32'd0);
    send(vecs[0]);
    drain();
    check("resv_word_count", 32'(word_count), 32'd1);

    // Flush while FULL coinciding with both handshakes
    out_ready = 1'b0;
    send(vecs[1]);
    fmt = vecs[2].fmt; opcode = vecs[2].opcode; address = vecs[2].address;
    in_valid = 1'b1;
    out_ready = 1'b1;
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    in_valid = 1'b0;
    exp_q.delete();
    model_idx = '0;
    check("flushfull_out_valid", 32'(out_valid), 32'd0);
    check("flushfull_word_count", 32'(word_count), 32'd0);
    check("flushfull_err", 32'(err), 32'd0);
    check("flushfull_wrapped", 32'(wrapped), 32'd0);
    send(vecs[2]);
    drain();

    // Asynchronous reset while FULL
    out_ready = 1'b0;
    send(vecs[3]);
    #2 reset_n = 1'b0;
    #1;
    check("rstfull_out_valid", 32'(out_valid), 32'd0);
    check("rstfull_out_addr", out_addr, BASE);
    check("rstfull_word_count", 32'(word_count), 32'd0);
    check("rstfull_in_ready", 32'(in_ready), 32'd1);
    exp_q.delete();
    model_idx = '0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    out_ready = 1'b1;
    send(vecs[0]);
    drain();
    check("rstfull_word_count_after", 32'(word_count), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
